custom_axi_lite_arbiter: RTL and testbench

//  Round-robin arbiter sharing the custom AXI-Lite IP slave between NUM_MST AXI-Lite requesters.

---
 rtl/custom_axi_lite_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_custom_axi_lite_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_axi_lite_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite slave among NUM_MST requesters; read and write paths
// arbitrate independently. Optional slave-stall timeout: CUSTOM_AXI_ARB_TIMEOUT_EN.
module custom_axi_lite_arbiter #(
  parameter int NUM_MST        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_MST*ADDR_W-1:0]  s_awaddr_i,
  input  logic [NUM_MST-1:0]         s_awvalid_i,
  output logic [NUM_MST-1:0]         s_awready_o,
  input  logic [NUM_MST*DATA_W-1:0]  s_wdata_i,
  input  logic [NUM_MST*DATA_W/8-1:0] s_wstrb_i,
  input  logic [NUM_MST-1:0]         s_wvalid_i,
  output logic [NUM_MST-1:0]         s_wready_o,
  output logic [NUM_MST*2-1:0]       s_bresp_o,
  output logic [NUM_MST-1:0]         s_bvalid_o,
  input  logic [NUM_MST-1:0]         s_bready_i,
  input  logic [NUM_MST*ADDR_W-1:0]  s_araddr_i,
  input  logic [NUM_MST-1:0]         s_arvalid_i,
  output logic [NUM_MST-1:0]         s_arready_o,
  output logic [NUM_MST*DATA_W-1:0]  s_rdata_o,
  output logic [NUM_MST*2-1:0]       s_rresp_o,
  output logic [NUM_MST-1:0]         s_rvalid_o,
  input  logic [NUM_MST-1:0]         s_rready_i,
  output logic [ADDR_W-1:0]          m_awaddr_o,
  output logic                       m_awvalid_o,
  input  logic                       m_awready_i,
  output logic [DATA_W-1:0]          m_wdata_o,
  output logic [DATA_W/8-1:0]        m_wstrb_o,
  output logic                       m_wvalid_o,
  input  logic                       m_wready_i,
  input  logic [1:0]                 m_bresp_i,
  input  logic                       m_bvalid_i,
  output logic                       m_bready_o,
  output logic [ADDR_W-1:0]          m_araddr_o,
  output logic                       m_arvalid_o,
  input  logic                       m_arready_i,
  input  logic [DATA_W-1:0]          m_rdata_i,
  input  logic [1:0]                 m_rresp_i,
  input  logic                       m_rvalid_i,
  output logic                       m_rready_o
);
  localparam int GW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {WR_IDLE, WR_XFER, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;

  wr_state_t wr_state_reg, wr_state_next;
  rd_state_t rd_state_reg, rd_state_next;
  logic [GW-1:0] wgrant_reg, wgrant_next, wptr_reg, wptr_next;
  logic [GW-1:0] rgrant_reg, rgrant_next, rptr_reg, rptr_next;
  logic aw_done_reg, aw_done_next, w_done_reg, w_done_next;
  logic [GW:0] wr_pick, rd_pick;
  logic wr_aw_rdy, wr_w_rdy, wr_b_valid, rd_ar_rdy, rd_r_valid;
  logic [1:0] wr_b_resp, rd_r_resp;
  logic [DATA_W-1:0] rd_r_data;
  logic wr_tmo, rd_tmo;

  // First requester at or after ptr, wrapping; MSB flags that someone was found.
  function automatic logic [GW:0] rr_pick(input logic [NUM_MST-1:0] req, input logic [GW-1:0] ptr);
    logic [GW:0]   res;
    logic [GW-1:0] idx;
    res = '0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      idx = GW'((int'(ptr) + i) % NUM_MST);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
    return (int'(g) + 1 >= NUM_MST) ? '0 : GW'(int'(g) + 1);
  endfunction

`ifdef CUSTOM_AXI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic IDLE_DRAIN = 1'b1;
  logic [CW-1:0] wcnt_reg, rcnt_reg;

  assign wr_tmo = (wcnt_reg == CW'(TIMEOUT_CYCLES));
  assign rd_tmo = (rcnt_reg == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_reg <= '0;
      rcnt_reg <= '0;
    end else begin
      if (wr_state_reg == WR_IDLE) wcnt_reg <= '0;
      else if (!wr_tmo)            wcnt_reg <= wcnt_reg + 1'b1;
      if (rd_state_reg == RD_IDLE) rcnt_reg <= '0;
      else if (!rd_tmo)            rcnt_reg <= rcnt_reg + 1'b1;
    end
  end
`else
  localparam logic IDLE_DRAIN = 1'b0;
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  assign wr_tmo = 1'b0;
  assign rd_tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_reg <= WR_IDLE;
      rd_state_reg <= RD_IDLE;
      wgrant_reg   <= '0;
      wptr_reg     <= '0;
      rgrant_reg   <= '0;
      rptr_reg     <= '0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
      wgrant_reg   <= wgrant_next;
      wptr_reg     <= wptr_next;
      rgrant_reg   <= rgrant_next;
      rptr_reg     <= rptr_next;
      aw_done_reg  <= aw_done_next;
      w_done_reg   <= w_done_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    wgrant_next   = wgrant_reg;
    wptr_next     = wptr_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    m_awaddr_o    = '0;
    m_awvalid_o   = 1'b0;
    m_wdata_o     = '0;
    m_wstrb_o     = '0;
    m_wvalid_o    = 1'b0;
    m_bready_o    = 1'b0;
    wr_aw_rdy     = 1'b0;
    wr_w_rdy      = 1'b0;
    wr_b_valid    = 1'b0;
    wr_b_resp     = 2'b00;
    wr_pick       = rr_pick(s_awvalid_i & s_wvalid_i, wptr_reg);
    unique case (wr_state_reg)
      WR_IDLE: begin
        m_bready_o = IDLE_DRAIN;
        if (wr_pick[GW]) begin
          wgrant_next   = wr_pick[GW-1:0];
          wr_state_next = WR_XFER;
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
        end
      end
      WR_XFER: if (!wr_tmo) begin
        m_awaddr_o   = s_awaddr_i[wgrant_reg*ADDR_W +: ADDR_W];
        m_wdata_o    = s_wdata_i[wgrant_reg*DATA_W +: DATA_W];
        m_wstrb_o    = s_wstrb_i[wgrant_reg*SW +: SW];
        m_awvalid_o  = !aw_done_reg && s_awvalid_i[wgrant_reg];
        m_wvalid_o   = !w_done_reg && s_wvalid_i[wgrant_reg];
        wr_aw_rdy    = !aw_done_reg && m_awready_i;
        wr_w_rdy     = !w_done_reg && m_wready_i;
        aw_done_next = aw_done_reg | (m_awvalid_o && m_awready_i);
        w_done_next  = w_done_reg | (m_wvalid_o && m_wready_i);
        if (aw_done_next && w_done_next) wr_state_next = WR_RESP;
      end
      WR_RESP: if (!wr_tmo) begin
        wr_b_valid = m_bvalid_i;
        wr_b_resp  = m_bresp_i;
        m_bready_o = s_bready_i[wgrant_reg];
        if (m_bvalid_i && s_bready_i[wgrant_reg]) begin
          wr_state_next = WR_IDLE;
          wptr_next     = rr_next(wgrant_reg);
        end
      end
      default: wr_state_next = WR_IDLE;
    endcase
    // A stalled slave is abandoned: the requester gets SLVERR, late slave B beats are swallowed.
    if (wr_tmo && wr_state_reg != WR_IDLE) begin
      wr_b_valid = 1'b1;
      wr_b_resp  = 2'b10;
      m_bready_o = 1'b1;
      if (s_bready_i[wgrant_reg]) begin
        wr_state_next = WR_IDLE;
        wptr_next     = rr_next(wgrant_reg);
      end
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rgrant_next   = rgrant_reg;
    rptr_next     = rptr_reg;
    m_araddr_o    = '0;
    m_arvalid_o   = 1'b0;
    m_rready_o    = 1'b0;
    rd_ar_rdy     = 1'b0;
    rd_r_valid    = 1'b0;
    rd_r_resp     = 2'b00;
    rd_r_data     = '0;
    rd_pick       = rr_pick(s_arvalid_i, rptr_reg);
    unique case (rd_state_reg)
      RD_IDLE: begin
        m_rready_o = IDLE_DRAIN;
        if (rd_pick[GW]) begin
          rgrant_next   = rd_pick[GW-1:0];
          rd_state_next = RD_ADDR;
        end
      end
      RD_ADDR: if (!rd_tmo) begin
        m_araddr_o  = s_araddr_i[rgrant_reg*ADDR_W +: ADDR_W];
        m_arvalid_o = s_arvalid_i[rgrant_reg];
        rd_ar_rdy   = m_arready_i;
        if (m_arvalid_o && m_arready_i) rd_state_next = RD_DATA;
      end
      RD_DATA: if (!rd_tmo) begin
        rd_r_valid = m_rvalid_i;
        rd_r_resp  = m_rresp_i;
        rd_r_data  = m_rdata_i;
        m_rready_o = s_rready_i[rgrant_reg];
        if (m_rvalid_i && s_rready_i[rgrant_reg]) begin
          rd_state_next = RD_IDLE;
          rptr_next     = rr_next(rgrant_reg);
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
    if (rd_tmo && rd_state_reg != RD_IDLE) begin
      rd_r_valid = 1'b1;
      rd_r_resp  = 2'b10;
      m_rready_o = 1'b1;
      if (s_rready_i[rgrant_reg]) begin
        rd_state_next = RD_IDLE;
        rptr_next     = rr_next(rgrant_reg);
      end
    end
  end

  // Requester-side fan-out: only the granted slice ever sees ready/valid/resp.
  for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_mst
    logic wsel, rsel;
    assign wsel = (wgrant_reg == GW'(gi));
    assign rsel = (rgrant_reg == GW'(gi));
    assign s_awready_o[gi]             = wsel && wr_aw_rdy;
    assign s_wready_o[gi]              = wsel && wr_w_rdy;
    assign s_bvalid_o[gi]              = wsel && wr_b_valid;
    assign s_bresp_o[gi*2 +: 2]        = wsel ? wr_b_resp : 2'b00;
    assign s_arready_o[gi]             = rsel && rd_ar_rdy;
    assign s_rvalid_o[gi]              = rsel && rd_r_valid;
    assign s_rresp_o[gi*2 +: 2]        = rsel ? rd_r_resp : 2'b00;
    assign s_rdata_o[gi*DATA_W +: DATA_W] = rsel ? rd_r_data : '0;
  end
endmodule

// File: tb/tb_custom_axi_lite_arbiter.sv
// Directed + randomized bench for custom_axi_lite_arbiter (2 masters); expected grants come from
// a round-robin pointer model, payloads from per-transaction random values.
module tb_custom_axi_lite_arbiter;
  localparam int N   = 2;
  localparam int TMO = 16;
`ifdef CUSTOM_AXI_ARB_TIMEOUT_EN
  localparam logic IDLE_RDY = 1'b1;
`else
  localparam logic IDLE_RDY = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [63:0] s_awaddr_i, s_wdata_i, s_araddr_i, s_rdata_o;
  logic [7:0]  s_wstrb_i;
  logic [1:0]  s_awvalid_i, s_awready_o, s_wvalid_i, s_wready_o, s_bvalid_o, s_bready_i;
  logic [1:0]  s_arvalid_i, s_arready_o, s_rvalid_o, s_rready_i;
  logic [3:0]  s_bresp_o, s_rresp_o;
  logic [31:0] m_awaddr_o, m_wdata_o, m_araddr_o, m_rdata_i;
  logic [3:0]  m_wstrb_o;
  logic        m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i, m_bvalid_i, m_bready_o;
  logic        m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;
  logic [1:0]  m_bresp_i, m_rresp_i;

  int vectors = 0;
  int miscompares = 0;
  int wptr_m = 0;
  int rptr_m = 0;
  logic [31:0] addr_t [2];
  logic [31:0] data_t [2];
  logic [3:0]  strb_t [2];

  always #5 clk_i = ~clk_i;

  custom_axi_lite_arbiter #(.NUM_MST(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Next owner: first requester at or after the pointer, wrapping around.
  function automatic int pick(input int pend, input int ptr);
    for (int o = 0; o < N; o++)
      if (((pend >> ((ptr + o) % N)) & 1) == 1) return (ptr + o) % N;
    return 0;
  endfunction

  function automatic logic [1:0] bitm(input int k);
    return 2'(1 << k);
  endfunction

  function automatic logic [3:0] resp_at(input int k, input logic [1:0] r);
    return (k == 1) ? {r, 2'b00} : {2'b00, r};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, ".m_awvalid"}, m_awvalid_o, 1'b0);
    chk({tag, ".m_wvalid"},  m_wvalid_o,  1'b0);
    chk({tag, ".m_arvalid"}, m_arvalid_o, 1'b0);
    chk({tag, ".m_bready"},  m_bready_o,  IDLE_RDY);
    chk({tag, ".m_rready"},  m_rready_o,  IDLE_RDY);
    chk({tag, ".m_awaddr"},  m_awaddr_o,  32'h0);
    chk({tag, ".m_wdata"},   m_wdata_o,   32'h0);
    chk({tag, ".m_araddr"},  m_araddr_o,  32'h0);
    chk({tag, ".s_readys"},  {s_awready_o, s_wready_o, s_arready_o}, 6'h0);
    chk({tag, ".s_valids"},  {s_bvalid_o, s_rvalid_o}, 4'h0);
    chk({tag, ".s_resps"},   {s_bresp_o, s_rresp_o}, 8'h0);
    chk({tag, ".s_rdata"},   s_rdata_o, 64'h0);
  endtask

  task automatic write_round(input int req, input int aw_dly, input int w_dly);
    int pend, w, n;
    bit awd, wd;
    logic [1:0] br;
    pend = req;
    for (int k = 0; k < N; k++) begin
      addr_t[k] = $urandom & 32'hFFFF_FFFC;
      data_t[k] = $urandom;
      strb_t[k] = 4'($urandom_range(1, 15));
    end
    s_awaddr_i  = {addr_t[1], addr_t[0]};
    s_wdata_i   = {data_t[1], data_t[0]};
    s_wstrb_i   = {strb_t[1], strb_t[0]};
    s_awvalid_i = 2'(req);
    s_wvalid_i  = 2'(req);
    while (pend != 0) begin
      w = pick(pend, wptr_m);
      cyc();
      awd = 0; wd = 0; n = 0;
      br  = 2'($urandom_range(0, 3));
      while (!(awd && wd)) begin
        m_awready_i = (n >= aw_dly);
        m_wready_i  = (n >= w_dly);
        m_bvalid_i  = 1'b1;   // early B from slave must not leak before both handshakes
        m_bresp_i   = br;
        settle();
        chk("wr.m_awvalid", m_awvalid_o, !awd);
        chk("wr.m_wvalid",  m_wvalid_o,  !wd);
        if (!awd) chk("wr.m_awaddr", m_awaddr_o, addr_t[w]);
        if (!wd) begin
          chk("wr.m_wdata", m_wdata_o, data_t[w]);
          chk("wr.m_wstrb", m_wstrb_o, strb_t[w]);
        end
        chk("wr.s_awready", s_awready_o, (!awd && m_awready_i) ? bitm(w) : 2'b00);
        chk("wr.s_wready",  s_wready_o,  (!wd && m_wready_i) ? bitm(w) : 2'b00);
        chk("wr.s_bvalid_early", s_bvalid_o, 2'b00);
        chk("wr.m_bready_early", m_bready_o, 1'b0);
        cyc();
        if (!awd && m_awready_i) begin awd = 1; s_awvalid_i &= ~bitm(w); end
        if (!wd && m_wready_i)   begin wd = 1;  s_wvalid_i  &= ~bitm(w); end
        n++;
      end
      m_awready_i = 1'b0;
      m_wready_i  = 1'b0;
      s_bready_i  = bitm(w);
      settle();
      chk("wr.s_bvalid", s_bvalid_o, bitm(w));
      chk("wr.s_bresp",  s_bresp_o,  resp_at(w, br));
      chk("wr.m_bready", m_bready_o, 1'b1);
      chk("wr.m_awvalid_resp", {m_awvalid_o, m_wvalid_o}, 2'b00);
      cyc();
      m_bvalid_i = 1'b0;
      m_bresp_i  = 2'b00;
      s_bready_i = 2'b00;
      wptr_m = (w + 1) % N;
      pend &= ~(1 << w);
      $display("write: master %0d served, bresp=%0d", w, br);
    end
  endtask

  task automatic read_round(input int req, input int ar_dly, input int r_dly);
    int pend, w;
    logic [31:0] rd;
    logic [1:0]  rr;
    pend = req;
    for (int k = 0; k < N; k++) addr_t[k] = $urandom & 32'hFFFF_FFFC;
    s_araddr_i  = {addr_t[1], addr_t[0]};
    s_arvalid_i = 2'(req);
    while (pend != 0) begin
      w = pick(pend, rptr_m);
      cyc();
      for (int c = 0; c <= ar_dly; c++) begin
        m_arready_i = (c == ar_dly);
        settle();
        chk("rd.m_arvalid", m_arvalid_o, 1'b1);
        chk("rd.m_araddr",  m_araddr_o,  addr_t[w]);
        chk("rd.s_arready", s_arready_o, m_arready_i ? bitm(w) : 2'b00);
        cyc();
      end
      s_arvalid_i &= ~bitm(w);
      m_arready_i = 1'b0;
      s_rready_i  = bitm(w);
      rd = $urandom;
      rr = 2'($urandom_range(0, 3));
      for (int c = 0; c < r_dly; c++) begin
        settle();
        chk("rd.s_rvalid_wait", s_rvalid_o, 2'b00);
        chk("rd.m_arvalid_wait", m_arvalid_o, 1'b0);
        cyc();
      end
      m_rvalid_i = 1'b1;
      m_rdata_i  = rd;
      m_rresp_i  = rr;
      settle();
      chk("rd.s_rvalid", s_rvalid_o, bitm(w));
      chk("rd.s_rdata",  s_rdata_o,  (w == 1) ? {rd, 32'h0} : {32'h0, rd});
      chk("rd.s_rresp",  s_rresp_o,  resp_at(w, rr));
      chk("rd.m_rready", m_rready_o, 1'b1);
      cyc();
      m_rvalid_i = 1'b0;
      m_rdata_i  = 32'h0;
      m_rresp_i  = 2'b00;
      s_rready_i = 2'b00;
      rptr_m = (w + 1) % N;
      pend &= ~(1 << w);
      $display("read: master %0d served, rdata=%08h rresp=%0d", w, rd, rr);
    end
  endtask

  initial begin
    s_awaddr_i = '0; s_wdata_i = '0; s_wstrb_i = '0; s_araddr_i = '0;
    s_awvalid_i = '0; s_wvalid_i = '0; s_bready_i = '0; s_arvalid_i = '0; s_rready_i = '0;
    m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bresp_i = '0;
    m_arready_i = 0; m_rvalid_i = 0; m_rdata_i = '0; m_rresp_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_quiet("reset");
    cyc();
    rst_ni = 1'b1;

    write_round(1, 0, 0);                 // lone M0 write
    write_round(3, 0, 0);                 // simultaneous pair after reset
    write_round(1, 0, 0);
    write_round(3, 0, 0);                 // pointer now favours M1
    write_round(1, 3, 0);                 // W accepted before AW
    write_round(2, 0, 3);                 // AW accepted before W
    read_round(3, 0, 0);
    read_round(1, 2, 1);

    // Concurrent write by M0 and read of 0x20 by M1.
    addr_t[0] = 32'h10; data_t[0] = 32'hDEADBEEF;
    s_awaddr_i = {32'h0, addr_t[0]}; s_wdata_i = {32'h0, data_t[0]}; s_wstrb_i = 8'h0F;
    s_araddr_i = {32'h20, 32'h0};
    s_awvalid_i = 2'b01; s_wvalid_i = 2'b01; s_arvalid_i = 2'b10;
    m_awready_i = 1; m_wready_i = 1; m_arready_i = 1;
    cyc();
    settle();
    chk("par.m_awaddr", m_awaddr_o, 32'h10);
    chk("par.m_araddr", m_araddr_o, 32'h20);
    chk("par.valids", {m_awvalid_o, m_wvalid_o, m_arvalid_o}, 3'b111);
    chk("par.s_awready", s_awready_o, pick(1, wptr_m) == 0 ? 2'b01 : 2'b00);
    chk("par.s_arready", s_arready_o, 2'b10);
    cyc();
    s_awvalid_i = 0; s_wvalid_i = 0; s_arvalid_i = 0;
    m_awready_i = 0; m_wready_i = 0; m_arready_i = 0;
    m_bvalid_i = 1; m_bresp_i = 2'b00; m_rvalid_i = 1; m_rdata_i = 32'h1234; m_rresp_i = 2'b00;
    s_bready_i = 2'b01; s_rready_i = 2'b10;
    settle();
    chk("par.s_bvalid", s_bvalid_o, 2'b01);
    chk("par.s_rvalid", s_rvalid_o, 2'b10);
    chk("par.s_rdata",  s_rdata_o,  {32'h1234, 32'h0});
    cyc();
    m_bvalid_i = 0; m_rvalid_i = 0; m_rdata_i = 0; s_bready_i = 0; s_rready_i = 0;
    wptr_m = 1; rptr_m = 0;
    $display("parallel: M0 write and M1 read served together");

    // Reset asserted while the write path waits in its response phase.
    s_awaddr_i = {32'h0, 32'h44}; s_awvalid_i = 2'b01; s_wvalid_i = 2'b01;
    m_awready_i = 1; m_wready_i = 1;
    cyc();
    cyc();
    s_awvalid_i = 0; s_wvalid_i = 0; m_awready_i = 0; m_wready_i = 0;
    m_bvalid_i = 1; s_bready_i = 2'b00;
    settle();
    chk("rstmid.s_bvalid_before", s_bvalid_o, 2'b01);
    rst_ni = 1'b0;
    #1;
    chk_quiet("rstmid");
    cyc();
    m_bvalid_i = 0;
    rst_ni = 1'b1;
    wptr_m = 0; rptr_m = 0;
    $display("reset mid-response: outputs cleared");
    write_round(2, 0, 0);

    // Slave never accepts AR from M0.
    s_araddr_i = {32'h0, 32'h80}; s_arvalid_i = 2'b01;
    cyc();
`ifdef CUSTOM_AXI_ARB_TIMEOUT_EN
    for (int k = 0; k < TMO; k++) begin
      settle();
      chk("tmo.s_rvalid_wait", s_rvalid_o, 2'b00);
      chk("tmo.m_arvalid", m_arvalid_o, 1'b1);
      cyc();
    end
    settle();
    chk("tmo.s_rvalid", s_rvalid_o, 2'b01);
    chk("tmo.s_rresp",  s_rresp_o,  4'b0010);
    chk("tmo.s_rdata",  s_rdata_o,  64'h0);
    chk("tmo.m_arvalid_drop", m_arvalid_o, 1'b0);
    s_rready_i = 2'b01; s_arvalid_i = 0;
    cyc();
    s_rready_i = 0;
`else
    for (int k = 0; k < 100; k++) begin
      settle();
      chk("stall.s_rvalid", s_rvalid_o, 2'b00);
      chk("stall.m_arvalid", m_arvalid_o, 1'b1);
      cyc();
    end
    m_arready_i = 1;
    cyc();
    s_arvalid_i = 0; m_arready_i = 0;
    m_rvalid_i = 1; m_rdata_i = 32'h5A5A; s_rready_i = 2'b01;
    settle();
    chk("stall.s_rvalid_late", s_rvalid_o, 2'b01);
    chk("stall.s_rdata_late",  s_rdata_o,  64'h5A5A);
    cyc();
    m_rvalid_i = 0; m_rdata_i = 0; s_rready_i = 0;
`endif
    rptr_m = 1;
    $display("stalled read: handled");

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1)
        write_round($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        read_round($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
